// File: rtl/bus_watchdog.sv
// Bus cycle watchdog: times unterminated 68k bus cycles against a programmable limit,
// raises BERR on timeout and counts faults. Optional rerun (HALT+BERR) via BUS_WATCHDOG_RERUN_EN.
module bus_watchdog #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ERR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             count,
  input  logic             ack,
  input  logic [CNT_W-1:0] timeout_limit,
  output logic             berr,
  output logic             halt,
  output logic             timeout_pulse,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);

  localparam int unsigned CMP_W = CNT_W + 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE, FAULT} state_t;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] timer_q, timer_n;
  logic             berr_n, pulse_n, busy_n;
  logic [ERR_W-1:0] err_n;
  logic             limit_zero, limit_hit, fault_entry;

`ifdef BUS_WATCHDOG_RERUN_EN
  logic halt_n, pend_q, pend_n;
`endif

  // Widened compare so a timer at the top of its range can never wrap past the limit.
  assign limit_zero = (timeout_limit == '0);
  assign limit_hit  = (CMP_W'(timer_q) + CMP_W'(1)) >= CMP_W'(timeout_limit);

  // Next-state and next-output logic
  always_comb begin
    state_n     = state_q;
    timer_n     = timer_q;
    berr_n      = berr;
    pulse_n     = 1'b0;
    err_n       = err_count;
    fault_entry = 1'b0;

    case (state_q)
      IDLE, COUNT: begin
        if (!count) begin
          state_n = IDLE;
          timer_n = '0;
        end else if (ack || limit_zero) begin
          state_n = DONE;
        end else begin
          timer_n = timer_q + CNT_W'(1);
          if (limit_hit) begin
            state_n     = FAULT;
            fault_entry = 1'b1;
          end else begin
            state_n = COUNT;
          end
        end
      end
      DONE, FAULT: begin
        if (!count) begin
          state_n = IDLE;
          timer_n = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (fault_entry) begin
      berr_n  = 1'b1;
      pulse_n = 1'b1;
      if (!(&err_count)) err_n = err_count + ERR_W'(1);
    end
    if (state_n == IDLE) berr_n = 1'b0;
    busy_n = (state_n != IDLE);

`ifdef BUS_WATCHDOG_RERUN_EN
    // First fault requests a rerun; a second consecutive fault gives up with BERR alone.
    halt_n = halt;
    pend_n = pend_q;
    if (fault_entry) begin
      halt_n = !pend_q;
      pend_n = !pend_q;
    end
    if (state_n == DONE && state_q != DONE) pend_n = 1'b0;
    if (state_n == IDLE) halt_n = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      berr          <= 1'b0;
      timeout_pulse <= 1'b0;
      busy          <= 1'b0;
      err_count     <= '0;
    end else begin
      state_q       <= state_n;
      timer_q       <= timer_n;
      berr          <= berr_n;
      timeout_pulse <= pulse_n;
      busy          <= busy_n;
      err_count     <= err_n;
    end
  end

`ifdef BUS_WATCHDOG_RERUN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      halt   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      halt   <= halt_n;
      pend_q <= pend_n;
    end
  end
`else
  assign halt = 1'b0;
`endif

endmodule

// File: tb/tb_bus_watchdog.sv
// Self-checking bench for bus_watchdog: directed scenarios plus random traffic against a
// cycle-level reference model.
module tb_bus_watchdog;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned ERR_W   = 4;
  localparam int          ERR_MAX = (1 << ERR_W) - 1;

  logic             clk;
  logic             reset, count, ack;
  logic [CNT_W-1:0] timeout_limit;
  logic             berr, halt, timeout_pulse, busy;
  logic [ERR_W-1:0] err_count;

  bus_watchdog #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .count(count), .ack(ack), .timeout_limit(timeout_limit),
    .berr(berr), .halt(halt), .timeout_pulse(timeout_pulse), .busy(busy), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a bus cycle is a run of edges with count=1; it resolves once,
  // either cleanly (ack or disabled watchdog) or by timing out after `lim` unacked edges.
  int m_run = 0;
  bit m_resolved = 0;
  bit m_berr = 0, m_halt = 0, m_pulse = 0, m_busy = 0, m_pend = 0;
  int m_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_edge(input bit r, input bit c, input bit a, input int lim);
    m_pulse = 0;
    if (r) begin
      m_run = 0; m_resolved = 0; m_berr = 0; m_halt = 0; m_busy = 0; m_pend = 0; m_err = 0;
      return;
    end
    m_busy = c;
    if (!c) begin
      m_run = 0; m_resolved = 0; m_berr = 0; m_halt = 0;
      return;
    end
    if (m_resolved) return;
    if (a || lim == 0) begin
      m_resolved = 1;
      m_pend = 0;
      return;
    end
    m_run++;
    if (m_run >= lim) begin
      m_resolved = 1;
      m_berr = 1;
      m_pulse = 1;
      if (m_err < ERR_MAX) m_err++;
`ifdef BUS_WATCHDOG_RERUN_EN
      m_halt = !m_pend;
      m_pend = !m_pend;
`endif
    end
  endfunction

  task automatic step(input bit r, input bit c, input bit a, input int lim);
    reset = r;
    count = c;
    ack = a;
    timeout_limit = CNT_W'(lim);
    @(posedge clk);
    model_edge(r, c, a, lim);
    #1;
    check_eq("berr", 32'(berr), 32'(m_berr));
    check_eq("halt", 32'(halt), 32'(m_halt));
    check_eq("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
    check_eq("busy", 32'(busy), 32'(m_busy));
    check_eq("err_count", 32'(err_count), 32'(m_err));
  endtask

  bit rc, ra, rr;
  int rlim;

  initial begin
    reset = 1'b1; count = 1'b0; ack = 1'b0; timeout_limit = '0;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_eq("reset_berr", 32'(berr), 32'd0);
    check_eq("reset_err", 32'(err_count), 32'd0);

    // Timeout at limit 4, then release
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, 4);
      if (i == 3) check_eq("t1_berr_early", 32'(berr), 32'd0);
    end
    check_eq("t1_berr", 32'(berr), 32'd1);
    check_eq("t1_pulse", 32'(timeout_pulse), 32'd1);
    step(0, 1, 1, 4);
    check_eq("t1_pulse_one", 32'(timeout_pulse), 32'd0);
    check_eq("t1_late_ack", 32'(berr), 32'd1);
    check_eq("t1_err", 32'(err_count), 32'd1);
    step(0, 0, 0, 4);
    check_eq("t1_release", 32'(berr), 32'd0);

    // Ack on the third counted clock
    step(0, 1, 0, 4);
    step(0, 1, 0, 4);
    step(0, 1, 1, 4);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 4);
    check_eq("t2_busy", 32'(busy), 32'd1);
    check_eq("t2_berr", 32'(berr), 32'd0);
    step(0, 0, 0, 4);
    check_eq("t2_idle", 32'(busy), 32'd0);
    check_eq("t2_err", 32'(err_count), 32'd1);

    // Disabled watchdog, then limit 1
    for (int i = 0; i < 300; i++) step(0, 1, 0, 0);
    check_eq("t3_disabled", 32'(berr), 32'd0);
    step(0, 0, 0, 1);
    step(0, 1, 0, 1);
    check_eq("t3_lim1", 32'(berr), 32'd1);
    step(0, 0, 0, 1);

    // Lower limit mid-cycle, then reset during fault
    for (int i = 0; i < 50; i++) step(0, 1, 0, 200);
    check_eq("t4_counting", 32'(berr), 32'd0);
    step(0, 1, 0, 10);
    check_eq("t4_lowered", 32'(berr), 32'd1);
    step(1, 1, 0, 10);
    check_eq("t4_rst_berr", 32'(berr), 32'd0);
    check_eq("t4_rst_busy", 32'(busy), 32'd0);
    check_eq("t4_rst_err", 32'(err_count), 32'd0);

    // Fault counter saturation
    for (int k = 0; k < 17; k++) begin
      step(0, 1, 0, 2);
      step(0, 1, 0, 2);
      step(0, 0, 0, 2);
    end
    check_eq("t5_sat", 32'(err_count), 32'd15);

`ifdef BUS_WATCHDOG_RERUN_EN
    step(1, 0, 0, 3);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 3);
    check_eq("t6_first_halt", 32'(halt), 32'd1);
    step(0, 0, 0, 3);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 3);
    check_eq("t6_second_halt", 32'(halt), 32'd0);
    check_eq("t6_second_berr", 32'(berr), 32'd1);
    step(0, 0, 0, 3);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 3);
    check_eq("t6_third_halt", 32'(halt), 32'd1);
    step(0, 0, 0, 3);
    step(0, 1, 1, 3);
    step(0, 0, 0, 3);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 3);
    check_eq("t6_after_ok_halt", 32'(halt), 32'd1);
    step(0, 0, 0, 3);
`endif

    // Random traffic
    rc = 0;
    rlim = 4;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 7) == 0) rc = !rc;
      if ($urandom_range(0, 15) == 0)
        rlim = ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 12));
      ra = ($urandom_range(0, 9) == 0);
      step(rr, rc, ra, rlim);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
